// File: rtl/mul_acc_ctrl_pkg.sv
// Shared types and constants for the multiply-class EX controller.
// Op encoding, FSM state type and the per-op class helpers live here.
package mul_acc_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MUL   = 3'd2,
        OP_MADD  = 3'd3,
        OP_MADDU = 3'd4,
        OP_MSUB  = 3'd5,
        OP_MSUBU = 3'd6,
        OP_RSVD  = 3'd7
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } mac_state_e;

    localparam mul_op_e     MAC_OP_RESERVED = OP_RSVD;
    localparam logic [63:0] HILO_RST_VAL    = 64'h0;

    function automatic logic is_signed_op(input mul_op_e op);
        return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_acc_op(input mul_op_e op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub_op(input mul_op_e op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/mul_acc_ctrl_if.sv
// Handshake and data bundle between the EX controller and the mul unit.
interface mul_acc_ctrl_if;
    logic        MUL_SIGNED;
    logic [31:0] MUL_A;
    logic [31:0] MUL_B;
    logic        MUL_START;
    logic        MUL_CANCEL;
    logic [63:0] MUL_RESULT;
    logic        MUL_READY;

    modport master (
        output MUL_SIGNED, MUL_A, MUL_B, MUL_START, MUL_CANCEL,
        input  MUL_RESULT, MUL_READY
    );

    modport slave (
        input  MUL_SIGNED, MUL_A, MUL_B, MUL_START, MUL_CANCEL,
        output MUL_RESULT, MUL_READY
    );
endinterface

// File: rtl/mul_acc_ctrl_fa64.sv
// 64-bit add/subtract; subtract is A + ~B + CARRY_I, so CARRY_I=1 gives A-B.
module fa64 (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        IS_SUB,
    input  logic        CARRY_I,
    output logic [63:0] SUM,
    output logic        CARRY_O
);
    logic [63:0] b_eff;

    assign b_eff          = B ^ {64{IS_SUB}};
    assign {CARRY_O, SUM} = {1'b0, A} + {1'b0, b_eff} + {64'h0, CARRY_I};
endmodule

// File: rtl/mul_acc_ctrl.sv
// EX-stage multiply-class controller: issues to mul, stalls until READY,
// owns HI/LO and runs the extra accumulate cycle for MADD/MSUB variants.
//
//   state   | meaning
//   IDLE    | no op in flight; issues START when a valid op arrives
//   WAIT    | operands sampled by mul, waiting for READY
//   ACC     | HI/LO += / -= captured product (MADD-class only)
//   DONE    | op retired, EX held by PIPE_HOLD; nothing re-issued
module mul_acc_ctrl
    import mul_acc_ctrl_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    input  logic           OP_VALID,
    input  logic [2:0]     OP,
    input  logic [31:0]    SRC_A,
    input  logic [31:0]    SRC_B,
    input  logic           PIPE_HOLD,
    input  logic           FLUSH,
    mul_acc_ctrl_if.master mul_bus,
    output logic           STALL_REQ,
    output logic [31:0]    GPR_RESULT,
    output logic           GPR_VALID,
    output logic [31:0]    HI,
    output logic [31:0]    LO
);

    mac_state_e  state_q;
    mul_op_e     op_q;
    mul_op_e     op_in;
    logic [63:0] hilo_q;
    logic [63:0] prod_q;
    logic [31:0] gpr_q;
    logic [63:0] acc_sum;
    logic        acc_sub;
    logic        carry_unused;
    logic        issue;

    assign op_in   = mul_op_e'(OP);
    assign issue   = (state_q == ST_IDLE) && OP_VALID && (op_in != MAC_OP_RESERVED) && !FLUSH;
    assign acc_sub = is_sub_op(op_q);

    fa64 u_fa64 (
        .A       (hilo_q),
        .B       (prod_q),
        .IS_SUB  (acc_sub),
        .CARRY_I (acc_sub),
        .SUM     (acc_sum),
        .CARRY_O (carry_unused)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            hilo_q  <= HILO_RST_VAL;
            prod_q  <= 64'h0;
            gpr_q   <= 32'h0;
        end else if (FLUSH) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        op_q    <= op_in;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mul_bus.MUL_READY) begin
                        if (is_acc_op(op_q)) begin
                            prod_q  <= mul_bus.MUL_RESULT;
                            state_q <= ST_ACC;
                        end else begin
                            if (op_q == OP_MUL) gpr_q  <= mul_bus.MUL_RESULT[31:0];
                            else                hilo_q <= mul_bus.MUL_RESULT;
                            state_q <= PIPE_HOLD ? ST_DONE : ST_IDLE;
                        end
                    end
                end
                ST_ACC: begin
                    hilo_q  <= acc_sum;
                    state_q <= PIPE_HOLD ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    if (!PIPE_HOLD) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // GPR result is live from mul in WAIT, then replayed from gpr_q while DONE holds EX.
    always_comb begin
        GPR_VALID  = 1'b0;
        GPR_RESULT = 32'h0;
        if (!FLUSH && (op_q == OP_MUL)) begin
            if ((state_q == ST_WAIT) && mul_bus.MUL_READY) begin
                GPR_VALID  = 1'b1;
                GPR_RESULT = mul_bus.MUL_RESULT[31:0];
            end else if (state_q == ST_DONE) begin
                GPR_VALID  = 1'b1;
                GPR_RESULT = gpr_q;
            end
        end
    end

    assign STALL_REQ = issue ||
                       (!FLUSH && (state_q == ST_WAIT) &&
                        (!mul_bus.MUL_READY || is_acc_op(op_q)));

    assign mul_bus.MUL_START  = issue;
    assign mul_bus.MUL_CANCEL = FLUSH;
    assign mul_bus.MUL_SIGNED = is_signed_op(op_in);
    assign mul_bus.MUL_A      = SRC_A;
    assign mul_bus.MUL_B      = SRC_B;

    assign HI = hilo_q[63:32];
    assign LO = hilo_q[31:0];

endmodule

// File: tb/tb_mul_acc_ctrl.sv
// Scoreboard bench for mul_acc_ctrl with a one-cycle behavioural multiplier.
module tb_mul_acc_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        OP_VALID = 1'b0;
    logic [2:0]  OP = 3'd0;
    logic [31:0] SRC_A = 32'h0;
    logic [31:0] SRC_B = 32'h0;
    logic        PIPE_HOLD = 1'b0;
    logic        FLUSH = 1'b0;
    logic        STALL_REQ;
    logic [31:0] GPR_RESULT;
    logic        GPR_VALID;
    logic [31:0] HI;
    logic [31:0] LO;

    mul_acc_ctrl_if m_if ();

    mul_acc_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .OP_VALID   (OP_VALID),
        .OP         (OP),
        .SRC_A      (SRC_A),
        .SRC_B      (SRC_B),
        .PIPE_HOLD  (PIPE_HOLD),
        .FLUSH      (FLUSH),
        .mul_bus    (m_if.master),
        .STALL_REQ  (STALL_REQ),
        .GPR_RESULT (GPR_RESULT),
        .GPR_VALID  (GPR_VALID),
        .HI         (HI),
        .LO         (LO)
    );

    always #5 CLK = ~CLK;

    // Multiplier stand-in: samples on the START edge, READY/RESULT valid the next cycle.
    function automatic logic [63:0] mul_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    always @(posedge CLK) begin
        if (RST || m_if.MUL_CANCEL) begin
            m_if.MUL_READY  <= 1'b0;
            m_if.MUL_RESULT <= 64'h0;
        end else if (m_if.MUL_START) begin
            m_if.MUL_READY  <= 1'b1;
            m_if.MUL_RESULT <= mul_model(m_if.MUL_SIGNED, m_if.MUL_A, m_if.MUL_B);
        end else begin
            m_if.MUL_READY  <= 1'b0;
            m_if.MUL_RESULT <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_hilo_q[$];
    logic [31:0] exp_gpr_q[$];
    logic [63:0] prev_hilo = 64'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever GPR_VALID is shown or HI/LO changes.
    always @(negedge CLK) begin
        if (RST) begin
            prev_hilo = {HI, LO};
        end else begin
            if (GPR_VALID) begin
                if (exp_gpr_q.size() == 0) chk("gpr_unexpected", {32'h0, GPR_RESULT}, 64'h0);
                else chk("gpr_result", {32'h0, GPR_RESULT}, {32'h0, exp_gpr_q.pop_front()});
            end
            if ({HI, LO} !== prev_hilo) begin
                if (exp_hilo_q.size() == 0) chk("hilo_unexpected", {HI, LO}, prev_hilo);
                else chk("hilo", {HI, LO}, exp_hilo_q.pop_front());
                prev_hilo = {HI, LO};
            end
        end
    end

    // Holds the op in EX until it advances; PIPE_HOLD is raised on cycles 1..hold.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int exp_stall, input int exp_start);
        int stalls;
        int starts;
        int cyc;
        logic adv;
        stalls = 0;
        starts = 0;
        cyc    = 0;
        adv    = 1'b0;
        OP_VALID = 1'b1;
        OP = op;
        SRC_A = a;
        SRC_B = b;
        while (!adv && cyc < 20) begin
            PIPE_HOLD = (cyc >= 1) && (cyc <= hold);
            @(negedge CLK);
            if (STALL_REQ) stalls++;
            if (m_if.MUL_START) starts++;
            adv = !STALL_REQ && !PIPE_HOLD;
            @(posedge CLK);
            #1;
            cyc++;
        end
        OP_VALID  = 1'b0;
        PIPE_HOLD = 1'b0;
        chk("op_timeout", {63'h0, adv}, 64'h1);
        chk("stall_cycles", stalls, exp_stall);
        chk("start_pulses", starts, exp_start);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_stall", {63'h0, STALL_REQ}, 64'h0);
        chk("rst_start", {63'h0, m_if.MUL_START}, 64'h0);
        chk("rst_cancel", {63'h0, m_if.MUL_CANCEL}, 64'h0);
        chk("rst_gpr_valid", {63'h0, GPR_VALID}, 64'h0);
        chk("rst_gpr_result", {32'h0, GPR_RESULT}, 64'h0);
        chk("rst_hilo", {HI, LO}, 64'h0);
        @(posedge CLK);
        #1;

        exp_hilo_q.push_back(64'hFFFFFFFF_FFFFFFFE);
        run_op(3'd0, 32'hFFFFFFFF, 32'h2, 0, 1, 1);           // MULT
        exp_hilo_q.push_back(64'h00000001_FFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'h2, 0, 1, 1);           // MULTU
        exp_gpr_q.push_back(32'h00030000);
        run_op(3'd2, 32'h00010003, 32'h00010000, 0, 1, 1);    // MUL
        @(negedge CLK);
        chk("mul_keeps_hilo", {HI, LO}, 64'h00000001_FFFFFFFE);
        @(posedge CLK);
        #1;

        exp_hilo_q.push_back(64'h00000000_00000005);
        run_op(3'd1, 32'h5, 32'h1, 0, 1, 1);                   // MULTU
        exp_hilo_q.push_back(64'hFFFFFFFF_FFFFFFFF);
        run_op(3'd6, 32'h3, 32'h2, 0, 2, 1);                   // MSUBU
        exp_hilo_q.push_back(64'hFFFFFFFF_FFFFFFFE);
        run_op(3'd3, 32'hFFFFFFFF, 32'h1, 0, 2, 1);           // MADD
        exp_hilo_q.push_back(64'h00000000_FFFFFFFE);
        run_op(3'd4, 32'h80000000, 32'h2, 0, 2, 1);           // MADDU, wraps
        exp_hilo_q.push_back(64'h00000001_00000004);
        run_op(3'd5, 32'hFFFFFFFE, 32'h3, 0, 2, 1);           // MSUB of -6

        // MADD flushed in its WAIT cycle
        OP_VALID = 1'b1;
        OP = 3'd3;
        SRC_A = 32'h2;
        SRC_B = 32'h3;
        @(negedge CLK);
        chk("flush_issue_start", {63'h0, m_if.MUL_START}, 64'h1);
        @(posedge CLK);
        #1 FLUSH = 1'b1;
        @(negedge CLK);
        chk("flush_cancel", {63'h0, m_if.MUL_CANCEL}, 64'h1);
        chk("flush_no_start", {63'h0, m_if.MUL_START}, 64'h0);
        chk("flush_stall", {63'h0, STALL_REQ}, 64'h0);
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        OP_VALID = 1'b0;
        @(negedge CLK);
        chk("post_flush_stall", {63'h0, STALL_REQ}, 64'h0);
        @(posedge CLK);
        @(negedge CLK);
        chk("flush_keeps_hilo", {HI, LO}, 64'h00000001_00000004);
        @(posedge CLK);
        #1;

        exp_hilo_q.push_back(64'h00000001_23456780);
        run_op(3'd1, 32'h12345678, 32'h10, 0, 1, 1);          // MULTU after flush
        run_op(3'd7, 32'h5, 32'h5, 0, 0, 0);                   // reserved: no-op

        repeat (4) exp_gpr_q.push_back(32'h0000002A);
        run_op(3'd2, 32'h7, 32'h6, 3, 1, 1);                   // MUL held 3 cycles

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("hold_end_gpr_valid", {63'h0, GPR_VALID}, 64'h0);
        chk("hilo_queue_drained", exp_hilo_q.size(), 64'h0);
        chk("gpr_queue_drained", exp_gpr_q.size(), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_acc_ctrl.md
# mul_acc_ctrl

EX-stage controller for all multiply-class instructions. It sits directly upstream of the `mul` Booth/Wallace multiplier: it issues operands and `START`, stalls the pipeline until `READY`, then consumes the 64-bit product. It owns the architectural HI/LO registers and performs the extra accumulate cycle for MADD/MADDU/MSUB/MSUBU. For MUL it returns the low word to the GPR write path.

## Interface
Parameters:
- none; operation encodings and state types come from the shared package.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `OP_VALID`  in  1  EX holds a multiply-class instruction.
- `OP`  in  3  0 MULT, 1 MULTU, 2 MUL, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 reserved (treated as no-op).
- `SRC_A`  in  32  rs operand; held stable by the pipeline while `STALL_REQ`=1.
- `SRC_B`  in  32  rt operand; same stability rule as `SRC_A`.
- `PIPE_HOLD`  in  1  EX will not advance this cycle for another reason.
- `FLUSH`  in  1  kill the in-flight op (exception or redirect).
- `MUL_SIGNED`  out  1  to `mul.SIGNED_MUL`.
- `MUL_A`, `MUL_B`  out  32  to `mul.MULTIPLICAND` / `mul.MULTIPLIER`, driven from `SRC_A`/`SRC_B`.
- `MUL_START`  out  1  to `mul.START`.
- `MUL_CANCEL`  out  1  to `mul.CANCEL`.
- `MUL_RESULT`  in  64  from `mul.RESULT`.
- `MUL_READY`  in  1  from `mul.READY`.
- `STALL_REQ`  out  1  freeze IF/ID/EX.
- `GPR_RESULT`  out  32  MUL low word.
- `GPR_VALID`  out  1  `GPR_RESULT` is valid (MUL only).
- `HI`, `LO`  out  32  architectural HI/LO registers.

## Operation
- States are IDLE, WAIT, ACC and DONE.
- IDLE:
  - With `OP_VALID` set, a valid `OP` and no `FLUSH`: `MUL_START`=1 and go to WAIT.
  - `MUL_SIGNED`=1 for MULT, MUL, MADD and MSUB.
- WAIT, when `MUL_READY`=1:
  - MULT/MULTU: {HI,LO} <= `MUL_RESULT`.
  - MUL: `GPR_RESULT` = `MUL_RESULT[31:0]`, `GPR_VALID`=1, HI/LO unchanged.
  - For these, the next state is DONE if `PIPE_HOLD`, else IDLE.
  - MADD-class: capture `MUL_RESULT` in `prod_q` and go to ACC.
- ACC:
  - {HI,LO} <= {HI,LO} + `prod_q` (MADD/MADDU) or − `prod_q` (MSUB/MSUBU).
  - The 64-bit result wraps modulo 2^64; signedness affects only the multiply.
  - Next state is DONE if `PIPE_HOLD`, else IDLE.
- DONE:
  - Never re-issues the op; HI/LO are not rewritten.
  - For MUL, `GPR_RESULT`/`GPR_VALID` are held.
  - Exit to IDLE on the first cycle with `PIPE_HOLD`=0.
- `STALL_REQ` is combinational:
  - 1 in IDLE when an op is being issued.
  - 1 in WAIT while `MUL_READY`=0.
  - 1 in WAIT for MADD-class ops.
  - 0 in ACC and DONE; DONE stalls only via the external `PIPE_HOLD`.
- `FLUSH` in any state:
  - `MUL_CANCEL`=1 and `MUL_START`=0.
  - No HI/LO write and no `GPR_VALID` that cycle.
  - Next state is IDLE; `STALL_REQ`=0.
- Reset: state IDLE; HI=LO=0; `prod_q`=0.
  - Combinational outputs then evaluate to `MUL_START`=0, `MUL_CANCEL`=0, `STALL_REQ`=0, `GPR_VALID`=0, `GPR_RESULT`=0.
  - Reset mid-op abandons the op. The multiplier must be reset by the same `RST`.

## Timing
- Issue cycle t: `mul` samples operands at edge t; `MUL_READY` and `MUL_RESULT` are valid during t+1.
- MULT/MULTU/MUL occupy EX for 2 cycles (1 stall cycle). HI/LO are written at the end of t+1 and read back new at t+2.
- MADD-class ops occupy EX for 3 cycles (2 stall cycles). HI/LO are written at the end of t+2.
- No internal HI/LO forwarding. A following MFHI/MFLO reads `HI`/`LO` at or after the cycle following the write.
- `MUL_READY` seen in IDLE or DONE is ignored.

## Structure
- The shared package holds:
  - `mul_op_e` (3-bit op encoding above);
  - `mac_state_e` (IDLE/WAIT/ACC/DONE);
  - the constants `MAC_OP_RESERVED` and the HI/LO reset value.
- One sub-module instance: the existing `fa64` for the ACC add/subtract.
  - Drive `IS_SUB` from the MSUB ops.
  - Tie `CARRY_I` per `fa64`'s subtract convention.
  - Leave `CARRY_O` unused.

## Test plan
1. Reset, then MULT 0xFFFFFFFF × 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; `STALL_REQ` high exactly 1 cycle; single `MUL_START` pulse.
2. MULTU 0xFFFFFFFF × 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
3. MUL 0x00010003 × 0x00010000 -> `GPR_RESULT`=0x00030000 with `GPR_VALID` in the issue cycle+1; HI/LO unchanged.
4. MULTU 5 × 1 (HI=0, LO=5), then MSUBU 3 × 2 -> {HI,LO}=0x00000000_FFFFFFFF−… precisely 5−6 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF; 2 stall cycles. Then MADD 0xFFFFFFFF × 0x00000001 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
5. MADD issued, `FLUSH` asserted in the WAIT cycle -> `MUL_CANCEL`=1, HI/LO unchanged, IDLE next cycle, `STALL_REQ`=0.
6. MUL completes with `PIPE_HOLD`=1 for 3 cycles -> one `MUL_START` only, `GPR_VALID` held all 3 cycles, return to IDLE when `PIPE_HOLD` drops.
